// File: rtl/alarm_pkg.sv
// Shared types, digit limits and the BCD digit-increment rule used by both
// the time-preload and alarm edit paths.
package alarm_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] digit_t;

    typedef enum logic [1:0] {
        MODE_IDLE      = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_t;

    typedef struct packed {
        bcd_t hd;
        bcd_t ho;
        bcd_t md;
        bcd_t mo;
    } hhmm_t;

    localparam bcd_t HOURDEC_MAX    = 4'd2;
    localparam bcd_t HOURONE_MAX_LO = 4'd9;
    localparam bcd_t HOURONE_MAX_HI = 4'd3;
    localparam bcd_t MINDEC_MAX     = 4'd5;
    localparam bcd_t MINONE_MAX     = 4'd9;

    // Bump one digit with wrap; no carry. ">=" compares also recover any
    // out-of-range digit back to zero.
    function automatic hhmm_t bcd_inc(input hhmm_t t, input digit_t sel);
        hhmm_t r;
        bcd_t  ho_max;
        r      = t;
        ho_max = (t.hd < HOURDEC_MAX) ? HOURONE_MAX_LO : HOURONE_MAX_HI;
        case (sel)
            2'd0: begin
                r.hd = (t.hd >= HOURDEC_MAX) ? 4'd0 : t.hd + 4'd1;
                if (r.hd == HOURDEC_MAX && t.ho > HOURONE_MAX_HI)
                    r.ho = HOURONE_MAX_HI;
            end
            2'd1:    r.ho = (t.ho >= ho_max)     ? 4'd0 : t.ho + 4'd1;
            2'd2:    r.md = (t.md >= MINDEC_MAX) ? 4'd0 : t.md + 4'd1;
            default: r.mo = (t.mo >= MINONE_MAX) ? 4'd0 : t.mo + 4'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton -> 2-FF sync -> stable-level counter -> one-cycle rising pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2, level, prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            prev  <= level;
            pulse <= level & ~prev;
            // any sample matching the accepted level restarts the count
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_time_setter.sv
// Button-driven editor for the HH:MM time preload and the alarm time.
module bcd_time_setter
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ALARM_RST_HD    = 0,
    parameter int ALARM_RST_HO    = 7,
    parameter int ALARM_RST_MD    = 0,
    parameter int ALARM_RST_MO    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic [3:0] now_hourdec,
    input  logic [3:0] now_hourone,
    input  logic [3:0] now_mindec,
    input  logic [3:0] now_minone,
    output logic [3:0] set_hourdec,
    output logic [3:0] set_hourone,
    output logic [3:0] set_mindec,
    output logic [3:0] set_minone,
    output logic       time_load,
    output logic [3:0] alarm_hourdec,
    output logic [3:0] alarm_hourone,
    output logic [3:0] alarm_mindec,
    output logic [3:0] alarm_minone,
    output logic       alarm_load,
    output logic [1:0] mode,
    output logic [1:0] digit_sel
);

    localparam hhmm_t ALARM_RST = '{hd: 4'(ALARM_RST_HD), ho: 4'(ALARM_RST_HO),
                                    md: 4'(ALARM_RST_MD), mo: 4'(ALARM_RST_MO)};

    logic   p_mode, p_inc, p_next;
    mode_t  state, state_n;
    digit_t dsel, dsel_n;
    hhmm_t  set_t, set_n, alarm_t, alarm_n, now_t;
    logic   tl_n, al_n;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst(rst), .raw(btn_mode), .pulse(p_mode));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .raw(btn_inc), .pulse(p_inc));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .raw(btn_next), .pulse(p_next));

    assign now_t = '{hd: now_hourdec, ho: now_hourone, md: now_mindec, mo: now_minone};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MODE_IDLE;
            dsel       <= '0;
            set_t      <= '0;
            alarm_t    <= ALARM_RST;
            time_load  <= 1'b0;
            alarm_load <= 1'b0;
        end else begin
            state      <= state_n;
            dsel       <= dsel_n;
            set_t      <= set_n;
            alarm_t    <= alarm_n;
            time_load  <= tl_n;
            alarm_load <= al_n;
        end
    end

    // mode wins over inc/next; inc uses the pre-advance digit_sel
    always_comb begin
        state_n = state;
        dsel_n  = dsel;
        set_n   = set_t;
        alarm_n = alarm_t;
        tl_n    = 1'b0;
        al_n    = 1'b0;
        if (p_mode) begin
            case (state)
                MODE_IDLE: begin
                    state_n = MODE_SET_TIME;
                    set_n   = now_t;
                    dsel_n  = '0;
                end
                MODE_SET_TIME: begin
                    state_n = MODE_SET_ALARM;
                    tl_n    = 1'b1;
                    dsel_n  = '0;
                end
                default: begin
                    state_n = MODE_IDLE;
                    al_n    = 1'b1;
                    dsel_n  = '0;
                end
            endcase
        end else if (state != MODE_IDLE) begin
            if (p_inc) begin
                if (state == MODE_SET_TIME) set_n   = bcd_inc(set_t, dsel);
                else                        alarm_n = bcd_inc(alarm_t, dsel);
            end
            if (p_next) dsel_n = dsel + 2'd1;
        end
    end

    assign mode          = state;
    assign digit_sel     = dsel;
    assign set_hourdec   = set_t.hd;
    assign set_hourone   = set_t.ho;
    assign set_mindec    = set_t.md;
    assign set_minone    = set_t.mo;
    assign alarm_hourdec = alarm_t.hd;
    assign alarm_hourone = alarm_t.ho;
    assign alarm_mindec  = alarm_t.md;
    assign alarm_minone  = alarm_t.mo;

endmodule

// File: doc/bcd_time_setter.md
Name: bcd_time_setter

Overview:
Button-driven front end that writes the BCD current-time preload and the alarm time into the alarm core, replacing the constants tied off at board top level. Three raw pushbuttons (mode / increment / next-digit) are synchronised, debounced and edge-detected. An FSM then edits a 4-digit HH:MM BCD shadow. The block emits the edited time with a one-cycle load strobe, and the alarm time as held registers.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, stable-level cycles required before a button change is accepted (10 ms at 100 MHz)
ALARM_RST_HD/HO/MD/MO, 0/7/0/0, alarm BCD digits after reset (07:00)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-high reset
btn_mode  in  1  raw button: cycle edit mode
btn_inc  in  1  raw button: increment selected digit
btn_next  in  1  raw button: select next digit
now_hourdec, now_hourone, now_mindec, now_minone  in  4 each  live BCD time from alarm core
set_hourdec, set_hourone, set_mindec, set_minone  out  4 each  edited time preload
time_load  out  1  one-cycle strobe: core loads set_* as current time
alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone  out  4 each  alarm time
alarm_load  out  1  one-cycle strobe on leaving alarm edit
mode  out  2  0=IDLE, 1=SET_TIME, 2=SET_ALARM (for LED/blink)
digit_sel  out  2  digit under edit: 0=hourdec, 1=hourone, 2=mindec, 3=minone

Behaviour:
- Reset (async, rst=1) sets: set_* = 0, alarm_* = ALARM_RST_*, time_load=0, alarm_load=0, mode=IDLE, digit_sel=0, debouncers at level 0 with counters cleared. Release is synchronous to clk.
- Button path, per button:
  - 2-FF synchroniser, then counter. The accepted level changes only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A rising edge of the accepted level gives a 1-cycle pulse.
  - Latency from a clean raw edge to pulse: 2 + DEBOUNCE_CYCLES + 1 cycles. A held button gives exactly one pulse, with no auto-repeat.
- FSM, on mode pulse:
  - IDLE -> SET_TIME: copy now_* into set_* shadow; digit_sel=0.
  - SET_TIME -> SET_ALARM: time_load=1 for exactly the next cycle; digit_sel=0.
  - SET_ALARM -> IDLE: alarm_load=1 for exactly the next cycle.
- next pulse in SET_*: digit_sel = (digit_sel+1) mod 4, wrapping 3->0.
- inc pulse in SET_TIME edits set_*. In SET_ALARM it edits alarm_*. Both next and inc are ignored in IDLE. Digit rules:
  - hourdec: 0->1->2->0. Entering 2 while hourone>3 clamps hourone to 3.
  - hourone: wraps 9->0 if hourdec<2, else wraps 3->0.
  - mindec: wraps 5->0.
  - minone: wraps 9->0.
  - No carry between digits. Each digit stays valid BCD at all times.
- Simultaneous pulses in one cycle:
  - mode has priority; inc/next are discarded.
  - inc+next: inc applies to the current digit_sel, then digit_sel advances.
- set_* is stable outside SET_TIME. alarm_* is written only by inc in SET_ALARM.
- Shadow copy happens once on entry; later now_* changes do not alter set_* during editing.
- Reset mid-edit: all state returns to reset values; no load strobe is emitted.

Decomposition:
- Package alarm_pkg:
  - mode_t enum {MODE_IDLE, MODE_SET_TIME, MODE_SET_ALARM}
  - digit_t (2-bit)
  - constants HOURDEC_MAX=2, HOURONE_MAX_LO=9, HOURONE_MAX_HI=3, MINDEC_MAX=5, MINONE_MAX=9
  - bcd digit typedef logic [3:0]
- Sub-module btn_debounce (sync + counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- Digit-increment logic is a function in alarm_pkg, shared by the time and alarm paths.

Test Plan (DEBOUNCE_CYCLES=4):
- Bounce filtering: btn_inc toggles every 2 cycles for 20 cycles, then held high, in SET_TIME, digit 3 -> exactly one increment, set_minone 0->1, pulse 7 cycles after the final stable edge.
- Time preload: now_*=1,1,4,9; mode once; inc on digit 3 -> set_*=11:40. Mode again -> time_load high exactly 1 cycle with set_*=11:40; mode=SET_ALARM.
- Hour wrap and clamp, in SET_ALARM:
  - alarm 19:00, inc on hourdec -> 29 clamped to 23.
  - inc on hourone -> 20.
  - From 23, inc hourone -> 20.
  - Inc hourdec at 2 -> 0.
- Digit navigation: next pressed 5 times in SET_TIME -> digit_sel sequence 1,2,3,0,1. Inc+next same cycle at digit 1 -> hourone increments, digit_sel=2.
- Mode priority and idle: mode+inc same cycle in SET_TIME -> no digit change, time_load pulse. inc/next in IDLE -> all outputs unchanged.
- Async reset mid-edit: rst asserted between clock edges in SET_ALARM with alarm edited to 12:34 -> outputs immediately show alarm 07:00, mode=0, digit_sel=0, no alarm_load.
